// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes, serializer
// states and the frame-length helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;

  // Clocks from one start edge to the next when frames run back to back.
  function automatic int frame_clocks(input int period, input int parity, input int stop_bits);
    return period * (10 + ((parity != PAR_NONE) ? 1 : 0) + (stop_bits - 1));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head word is visible
// combinationally on pop_data while the FIFO is non-empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8-bit UART transmitter: FIFO-fed serializer producing
// start, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int PERIOD    = 10,
  parameter int DEPTH     = 4,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int               CNT_W     = $clog2(PERIOD) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       bit_idx, bit_n;
  logic [7:0]       shift_r, shift_n;
  logic             par_r, par_n;
  logic             tx_n;
  logic             push, pop, bit_end;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_head;

  function automatic logic parity_of(input logic [7:0] d);
    return (PARITY == PAR_ODD) ? ~(^d) : (^d);
  endfunction

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  assign busy     = (state != IDLE);
  assign bit_end  = (cnt == CNT_LAST);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Control state; tx is registered so the line lags the state by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      tx      <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    shift_r <= shift_n;
    par_r   <= par_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift_r;
    par_n   = par_r;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = START;
          cnt_n   = '0;
          bit_n   = '0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        tx_n = shift_r[0];
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = shift_r >> 1;
          if (bit_idx == 4'd7) begin
            bit_n   = '0;
            state_n = (PARITY != PAR_NONE) ? PAR : STOP;
          end else begin
            bit_n = bit_idx + 4'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PAR: begin
        tx_n = par_r;
        if (bit_end) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_n = '0;
            // Chain straight into the next start bit when more bytes wait.
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_idx + 4'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (pop) begin
      shift_n = fifo_head;
      par_n   = parity_of(fifo_head);
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench: four transmitters (no parity/1 stop, no parity/2 stops,
// even parity, odd parity) at PERIOD=4; a per-instance monitor decodes tx.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int NI = 4;
  localparam int P  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data    [NI];
  logic       in_valid   [NI];
  logic       in_ready   [NI];
  logic       tx         [NI];
  logic       busy       [NI];
  logic [2:0] fifo_count [NI];
  logic       abort      [NI];

  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_q     [NI][$];
  int         start_log [NI][$];
  logic       par_log   [NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_buffered #(
      .PERIOD    (P),
      .DEPTH     (4),
      .PARITY    ((g == 2) ? PAR_EVEN : (g == 3) ? PAR_ODD : PAR_NONE),
      .STOP_BITS ((g == 1) ? 2 : 1)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .tx         (tx[g]),
      .busy       (busy[g]),
      .fifo_count (fifo_count[g])
    );
  end

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [dut%0d]: got %0d (0x%0h), expected %0d (0x%0h)", name, g, act, act, exp, exp);
  endtask

  // Decodes one frame per start bit, checking every bit holds for exactly P clocks.
  task automatic monitor(input int g);
    int         pm, ns, nb, t0, first_stop;
    logic [11:0] bits;
    logic       width_ok, stop_ok, exp_par;
    logic [7:0] e;
    pm = (g == 2) ? PAR_EVEN : (g == 3) ? PAR_ODD : PAR_NONE;
    ns = (g == 1) ? 2 : 1;
    first_stop = 9 + ((pm != PAR_NONE) ? 1 : 0);
    nb = first_stop + ns;
    forever begin
      @(posedge clk); #1;
      if (tx[g] === 1'b0) begin
        t0 = cyc;
        bits = '0;
        width_ok = 1'b1;
        for (int b = 0; b < nb; b++) begin
          for (int c = 0; c < P; c++) begin
            if (b != 0 || c != 0) begin @(posedge clk); #1; end
            if (c == 0) bits[b] = tx[g];
            else if (tx[g] !== bits[b]) width_ok = 1'b0;
          end
        end
        if (!abort[g]) begin
          start_log[g].push_back(t0);
          check("bit_width", g, width_ok, 1);
          stop_ok = 1'b1;
          for (int s = first_stop; s < nb; s++) if (bits[s] !== 1'b1) stop_ok = 1'b0;
          check("stop_bits", g, stop_ok, 1);
          check("frame_expected", g, exp_q[g].size() != 0, 1);
          if (exp_q[g].size() != 0) begin
            e = exp_q[g].pop_front();
            check("data_byte", g, bits[8:1], e);
            if (pm != PAR_NONE) begin
              exp_par = (pm == PAR_EVEN) ? ^e : ~(^e);
              par_log[g].push_back(bits[9]);
              check("parity_bit", g, bits[9], exp_par);
            end
          end
        end
      end
    end
  endtask

  task automatic push(input int g, input logic [7:0] d, output int acc);
    int waited;
    waited = 0;
    acc = -1;
    @(negedge clk);
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    while (in_ready[g] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready[g] !== 1'b1) begin
      n_total++;
      $display("FAIL push_timeout [dut%0d]: in_ready stayed low, byte 0x%0h not accepted", g, d);
    end else begin
      acc = cyc;
      exp_q[g].push_back(d);
      @(posedge clk); #1;
    end
  endtask

  task automatic release_in(input int g);
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((busy[g] !== 1'b0 || fifo_count[g] !== 3'd0) && n < 8000);
    check("idle_reached", g, (busy[g] === 1'b0 && fifo_count[g] === 3'd0), 1);
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", g, exp_q[g].size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, t, b0, lows;
    logic [7:0] d;
    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      in_valid[g] = 1'b0;
      in_data[g]  = 8'h00;
      abort[g]    = 1'b0;
    end
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      check("reset_tx", g, tx[g], 1);
      check("reset_busy", g, busy[g], 0);
      check("reset_count", g, fifo_count[g], 0);
      check("reset_ready", g, in_ready[g], 1);
    end

    // Single 0x55 frame: latency and end-of-frame timing
    push(0, 8'h55, a);
    release_in(0);
    @(posedge clk); #1;
    check("latency_tx_still_high", 0, tx[0], 1);
    check("busy_after_pop", 0, busy[0], 1);
    @(posedge clk); #1;
    check("latency_start_low", 0, tx[0], 0);
    repeat (38) @(posedge clk);
    #1;
    check("busy_last_frame_clock", 0, busy[0], 1);
    @(posedge clk); #1;
    check("busy_dropped", 0, busy[0], 0);
    check("tx_idle_after_frame", 0, tx[0], 1);
    wait_idle(0);

    // Held-valid burst 0x10..0x15 into a depth-4 FIFO
    b0 = start_log[0].size();
    push(0, 8'h10, a);
    for (int i = 1; i < 5; i++) push(0, 8'(8'h10 + i), t);
    check("burst_count_full", 0, fifo_count[0], 4);
    check("burst_ready_low", 0, in_ready[0], 0);
    push(0, 8'h15, t);
    check("stalled_accept_edge", 0, t - a, 42);
    check("count_refilled", 0, fifo_count[0], 4);
    release_in(0);
    wait_idle(0);
    check("burst_frames", 0, start_log[0].size() - b0, 6);
    for (int i = b0 + 1; i < start_log[0].size(); i++)
      check("burst_spacing", 0, start_log[0][i] - start_log[0][i-1], frame_clocks(P, PAR_NONE, 1));

    // 100 random bytes with valid held
    for (int i = 0; i < 100; i++) begin
      d = 8'($urandom_range(0, 255));
      push(0, d, t);
    end
    release_in(0);
    wait_idle(0);

    // Two stop bits: 0x00 then 0xFF back to back
    push(1, 8'h00, a);
    push(1, 8'hFF, t);
    release_in(1);
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (tx[1] === 1'b0) lows++;
    end
    check("low_clocks_two_frames", 1, lows, 40);
    wait_idle(1);
    check("b2b_spacing", 1, (start_log[1].size() >= 2) ? start_log[1][1] - start_log[1][0] : -1, 44);

    // Even parity: 0xA5 -> 0, 0x07 -> 1; odd parity: 0xA5 -> 1
    push(2, 8'hA5, a);
    push(2, 8'h07, t);
    release_in(2);
    wait_idle(2);
    check("even_par_count", 2, par_log[2].size(), 2);
    check("even_par_a5", 2, (par_log[2].size() >= 1) ? par_log[2][0] : 1'bx, 0);
    check("even_par_07", 2, (par_log[2].size() >= 2) ? par_log[2][1] : 1'bx, 1);
    check("parity_spacing", 2, (start_log[2].size() >= 2) ? start_log[2][1] - start_log[2][0] : -1, 44);
    push(3, 8'hA5, a);
    release_in(3);
    wait_idle(3);
    check("odd_par_a5", 3, (par_log[3].size() >= 1) ? par_log[3][0] : 1'bx, 1);

    // Reset during data bit 3 with three bytes queued
    abort[0] = 1'b1;
    push(0, 8'h31, a);
    push(0, 8'h32, t);
    push(0, 8'h33, t);
    push(0, 8'h34, t);
    release_in(0);
    check("queued_before_reset", 0, fifo_count[0], 3);
    repeat (15) @(posedge clk);
    #1;
    check("busy_before_reset", 0, busy[0], 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q[0].delete();
    check("reset_mid_tx", 0, tx[0], 1);
    check("reset_mid_count", 0, fifo_count[0], 0);
    check("reset_mid_busy", 0, busy[0], 0);
    check("reset_mid_ready", 0, in_ready[0], 1);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (tx[0] !== 1'b1) lows++;
      if (busy[0] !== 1'b0) lows++;
    end
    check("quiet_after_reset", 0, lows, 0);
    abort[0] = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
